uart_alu_ctrl: RTL and testbench
================================

# uart_alu_ctrl

Sequencing controller that connects the UART receiver/transmitter pair to a combinational ALU. It collects a three-byte command from the receiver (operand A, operand B, opcode), presents it to the ALU, and captures the result. It then starts the transmitter and waits for it to finish before accepting the next command. It sits between `uart_rx`/`uart_tx` (driven by the shared `baudRateGen` tick) and the ALU in the top level.

## Interface
- `NB_DATA`, 8: width of UART bytes, operands and ALU result.
- `NB_OP`, 6: opcode width. Taken from the low `NB_OP` bits of the third byte.
- `TIMEOUT_CYCLES`, 50000000: inter-byte timeout in clock cycles. Used only with `UART_ALU_CTRL_TIMEOUT_EN`. Minimum 2.

Ports:
- `i_clk`  in  1  system clock. The only clock in the block.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_rx_data`  in  NB_DATA  received byte. Valid in the cycle `i_rx_done` is high.
- `i_rx_done`  in  1  one-cycle pulse from `uart_rx`.
- `i_tx_done`  in  1  one-cycle pulse from `uart_tx` at end of stop bit.
- `i_alu_result`  in  NB_DATA  combinational ALU output.
- `o_alu_data_a`  out  NB_DATA  registered operand A.
- `o_alu_data_b`  out  NB_DATA  registered operand B.
- `o_alu_op`  out  NB_OP  registered opcode.
- `o_tx_data`  out  NB_DATA  registered result to `uart_tx`.
- `o_tx_start`  out  1  registered one-cycle start pulse to `uart_tx`.
- `o_busy`  out  1  high in EXEC, SEND and WAIT_TX.
- `o_rx_drop`  out  1  one-cycle pulse when a received byte is discarded because the block is busy.
- `o_timeout`  out  1  one-cycle pulse on inter-byte timeout. Constant 0 without the macro.

## Operation
- States: IDLE, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX. Reset state is IDLE.
- IDLE: on `i_rx_done`, load `o_alu_data_a` with `i_rx_data` and go to WAIT_B.
- WAIT_B: on `i_rx_done`, load `o_alu_data_b` and go to WAIT_OP.
- WAIT_OP: on `i_rx_done`, load `o_alu_op` with `i_rx_data[NB_OP-1:0]` and go to EXEC. Upper bits are discarded.
- EXEC: lasts one cycle. The ALU settles on the registered operands. At the end of the cycle, `i_alu_result` is latched into `o_tx_data`. Next state is SEND.
- SEND: lasts one cycle. `o_tx_start` is high. Next state is WAIT_TX.
- WAIT_TX: on `i_tx_done`, go to IDLE.
- An `i_rx_done` in EXEC, SEND or WAIT_TX discards the byte, pulses `o_rx_drop` for one cycle, and leaves the state unchanged.
- An `i_tx_done` outside WAIT_TX is ignored.
- Operand, opcode and result registers hold their values until overwritten.
- Reset values: all outputs and registers are 0 and the state is IDLE.
- Reset mid-operation: state returns to IDLE and `o_tx_start` is low in the cycle after reset is sampled. A late `i_tx_done` from an in-flight frame is then ignored in IDLE.

## Timing
- `i_rx_done` in cycle n updates the target register and state as of cycle n+1.
- The opcode byte's `i_rx_done` in cycle n gives:
  - EXEC in cycle n+1;
  - `o_tx_data` valid and `o_tx_start` high in cycle n+2;
  - WAIT_TX from cycle n+3.
- `o_tx_start` is high for exactly one cycle per command.
- `o_busy` is high from cycle n+1 until the cycle after `i_tx_done` is sampled.
- The earliest next command byte is accepted in the cycle after the return to IDLE. A byte whose `i_rx_done` coincides with the `i_tx_done` cycle is dropped.
- `o_rx_drop` and `o_timeout` are registered and appear one cycle after their cause.

## Configuration
- `UART_ALU_CTRL_TIMEOUT_EN` defined:
  - A counter clears on every accepted byte and increments each cycle in WAIT_B and WAIT_OP.
  - When the counter reaches `TIMEOUT_CYCLES`, the state returns to IDLE and `o_timeout` pulses once.
  - Partial operands are abandoned; register contents are unchanged.
  - A byte arriving in the same cycle the counter reaches `TIMEOUT_CYCLES` is accepted and the timeout does not fire.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- Not defined: no counter exists, WAIT_B and WAIT_OP wait indefinitely, and `o_timeout` is tied to 0.

## Test plan
- Bytes 0x05, 0x03, 0x20 with a bench ALU where op 0x20 is ADD: A=0x05, B=0x03, op=0x20, `o_tx_data`=0x08, one `o_tx_start` pulse 2 cycles after the third `i_rx_done`.
- Opcode byte 0xE2 with NB_OP=6: `o_alu_op`=0x22.
- Fourth byte 0xAA while in WAIT_TX: `o_rx_drop` pulses once, state unchanged, and the next command after `i_tx_done` computes correctly from fresh bytes.
- Reset asserted in WAIT_TX, then a late `i_tx_done`: all outputs 0, state IDLE, no `o_tx_start`, and the next byte 0x11 loads A.
- With the macro and TIMEOUT_CYCLES=20, send only 0x05 and wait 20 cycles: `o_timeout` pulses, state IDLE, and the next byte 0x07 loads A.
- Full loopback through baudRateGen, uart_rx and uart_tx (163 cycles per tick) with 10 random A/B pairs and op ADD: each received result equals (A+B) mod 256.

Source files
------------

// File: rtl/uart_alu_ctrl.sv
// ---------------------------------------------------------------------------
// uart_alu_ctrl
//
// Sequencing controller between a UART receiver/transmitter pair and a
// combinational ALU. Three received bytes (operand A, operand B, opcode) are
// collected into registers that drive the ALU. One cycle later the ALU result
// is captured and handed to the transmitter with a single start pulse. The
// block then waits for the transmitter to report completion before it accepts
// the next command.
//
// Optional feature (macro UART_ALU_CTRL_TIMEOUT_EN):
//   When defined, an inter-byte timeout abandons a partially received command
//   after TIMEOUT_CYCLES idle cycles in WAIT_B / WAIT_OP and pulses o_timeout.
//   When undefined, the block waits indefinitely and o_timeout is always 0.
//
// Ports:
//   i_clk         system clock (only clock in the block)
//   i_reset       synchronous, active-high reset
//   i_rx_data     received byte, valid while i_rx_done is high
//   i_rx_done     one-cycle pulse from uart_rx
//   i_tx_done     one-cycle pulse from uart_tx at end of stop bit
//   i_alu_result  combinational ALU output
//   o_alu_data_a  registered operand A
//   o_alu_data_b  registered operand B
//   o_alu_op      registered opcode (low NB_OP bits of the third byte)
//   o_tx_data     registered result for uart_tx
//   o_tx_start    registered one-cycle start pulse for uart_tx
//   o_busy        high in EXEC, SEND and WAIT_TX
//   o_rx_drop     one-cycle pulse when a byte is discarded while busy
//   o_timeout     one-cycle pulse on inter-byte timeout
// ---------------------------------------------------------------------------
module uart_alu_ctrl #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_data_a,
    output logic [NB_DATA-1:0] o_alu_data_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_rx_drop,
    output logic               o_timeout
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_WAIT_TX = 3'd5;

    // A timeout shorter than two cycles cannot be distinguished from the
    // byte-accept cycle, so reject it at elaboration.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_alu_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    logic [2:0]         state_r,    state_s;
    logic [NB_DATA-1:0] data_a_r,   data_a_s;
    logic [NB_DATA-1:0] data_b_r,   data_b_s;
    logic [NB_OP-1:0]   op_r,       op_s;
    logic [NB_DATA-1:0] tx_data_r,  tx_data_s;
    logic               tx_start_r, tx_start_s;
    logic               busy_r,     busy_s;
    logic               rx_drop_r,  rx_drop_s;
    logic               timeout_r,  timeout_s;
    logic               timeout_hit_s;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             in_wait_s;

    // Inter-byte counter: runs only while a command is partially received and
    // restarts from zero whenever a byte is accepted or the timeout fires.
    always_comb begin
        in_wait_s     = (state_r == ST_WAIT_B) || (state_r == ST_WAIT_OP);
        timeout_hit_s = 1'b0;
        cnt_s         = {CNT_W{1'b0}};
        if (in_wait_s && !i_rx_done) begin
            if (cnt_r == CNT_W'(TIMEOUT_CYCLES)) begin
                timeout_hit_s = 1'b1;
                cnt_s         = {CNT_W{1'b0}};
            end else begin
                timeout_hit_s = 1'b0;
                cnt_s         = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            timeout_hit_s = 1'b0;
            cnt_s         = {CNT_W{1'b0}};
        end
    end

    // Inter-byte counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_s;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Next-state and next-output logic of the command sequencer.
    always_comb begin
        state_s    = state_r;
        data_a_s   = data_a_r;
        data_b_s   = data_b_r;
        op_s       = op_r;
        tx_data_s  = tx_data_r;
        tx_start_s = 1'b0;
        busy_s     = busy_r;
        rx_drop_s  = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_rx_done) begin
                    data_a_s = i_rx_data;
                    state_s  = ST_WAIT_B;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_WAIT_B: begin
                // A byte in the expiry cycle wins over the timeout.
                if (i_rx_done) begin
                    data_b_s = i_rx_data;
                    state_s  = ST_WAIT_OP;
                end else if (timeout_hit_s) begin
                    state_s   = ST_IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_s   = ST_WAIT_B;
                end
            end
            ST_WAIT_OP: begin
                if (i_rx_done) begin
                    op_s    = i_rx_data[NB_OP-1:0];
                    state_s = ST_EXEC;
                    busy_s  = 1'b1;
                end else if (timeout_hit_s) begin
                    state_s   = ST_IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_s   = ST_WAIT_OP;
                end
            end
            ST_EXEC: begin
                // ALU has had a full cycle on the registered operands.
                tx_data_s  = i_alu_result;
                tx_start_s = 1'b1;
                state_s    = ST_SEND;
                rx_drop_s  = i_rx_done;
            end
            ST_SEND: begin
                state_s   = ST_WAIT_TX;
                rx_drop_s = i_rx_done;
            end
            ST_WAIT_TX: begin
                // A byte coinciding with i_tx_done is still dropped.
                rx_drop_s = i_rx_done;
                if (i_tx_done) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end else begin
                    state_s = ST_WAIT_TX;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r    <= ST_IDLE;
            data_a_r   <= {NB_DATA{1'b0}};
            data_b_r   <= {NB_DATA{1'b0}};
            op_r       <= {NB_OP{1'b0}};
            tx_data_r  <= {NB_DATA{1'b0}};
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
            rx_drop_r  <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            data_a_r   <= data_a_s;
            data_b_r   <= data_b_s;
            op_r       <= op_s;
            tx_data_r  <= tx_data_s;
            tx_start_r <= tx_start_s;
            busy_r     <= busy_s;
            rx_drop_r  <= rx_drop_s;
            timeout_r  <= timeout_s;
        end
    end

    assign o_alu_data_a = data_a_r;
    assign o_alu_data_b = data_b_r;
    assign o_alu_op     = op_r;
    assign o_tx_data    = tx_data_r;
    assign o_tx_start   = tx_start_r;
    assign o_busy       = busy_r;
    assign o_rx_drop    = rx_drop_r;
    assign o_timeout    = timeout_r;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_alu_ctrl
//
// Self-checking bench for uart_alu_ctrl. Commands are pushed into a
// scoreboard queue as they are issued; a monitor pops an entry on every
// o_tx_start and compares result and operands. Directed checks cover reset,
// start latency, opcode truncation, drops while busy, reset mid-frame and the
// inter-byte timeout (behaviour chosen by UART_ALU_CTRL_TIMEOUT_EN).
// ---------------------------------------------------------------------------
module tb_uart_alu_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] alu_result;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       rx_drop;
    logic       timeout;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] res;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   pushed = 0;
    int   starts = 0;

    uart_alu_ctrl #(
        .NB_DATA        (8),
        .NB_OP          (6),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_tx_done    (tx_done),
        .i_alu_result (alu_result),
        .o_alu_data_a (alu_a),
        .o_alu_data_b (alu_b),
        .o_alu_op     (alu_op),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_busy       (busy),
        .o_rx_drop    (rx_drop),
        .o_timeout    (timeout)
    );

    // Bench ALU: 0x20 ADD, 0x22 SUB, 0x24 AND.
    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            6'h24:   alu_result = alu_a & alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every start pulse must match the oldest outstanding command.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                starts++;
                if (q.size() == 0) begin
                    chk("unexpected_tx_start", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("tx_data", {24'd0, tx_data}, {24'd0, e.res});
                    chk("start_a", {24'd0, alu_a},   {24'd0, e.a});
                    chk("start_b", {24'd0, alu_b},   {24'd0, e.b});
                    chk("start_op", {26'd0, alu_op}, {26'd0, e.op});
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b,
                            input logic [5:0] op, input logic [7:0] res);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.res = res;
        q.push_back(e);
        pushed++;
    endtask

    task automatic send_byte(input logic [7:0] d);
        @(posedge clk); #1;
        rx_data = d;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] opb, input logic [7:0] res);
        push_exp(a, b, opb[5:0], res);
        send_byte(a);
        send_byte(b);
        send_byte(opb);
    endtask

    task automatic finish_cmd(input int delay);
        repeat (delay) @(negedge clk);
        pulse_tx_done();
        @(negedge clk);
        chk("busy_after_tx_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int tcount;
        logic [7:0] ra;
        logic [7:0] rb;
        reset   = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a",        {24'd0, alu_a},   32'd0);
        chk("rst_b",        {24'd0, alu_b},   32'd0);
        chk("rst_op",       {26'd0, alu_op},  32'd0);
        chk("rst_tx_data",  {24'd0, tx_data}, 32'd0);
        chk("rst_outputs",  {28'd0, tx_start, busy, rx_drop, timeout}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 05 + 03 with start-latency checks.
        push_exp(8'h05, 8'h03, 6'h20, 8'h08);
        send_byte(8'h05);
        @(negedge clk);
        chk("load_a", {24'd0, alu_a}, 32'h05);
        chk("idle_not_busy", {31'd0, busy}, 32'd0);
        send_byte(8'h03);
        @(negedge clk);
        chk("load_b", {24'd0, alu_b}, 32'h03);
        send_byte(8'h20);
        @(negedge clk);
        chk("exec_busy", {31'd0, busy}, 32'd1);
        chk("exec_no_start", {31'd0, tx_start}, 32'd0);
        chk("load_op", {26'd0, alu_op}, 32'h20);
        @(negedge clk);
        chk("start_at_n2", {31'd0, tx_start}, 32'd1);
        @(negedge clk);
        chk("start_one_cycle", {31'd0, tx_start}, 32'd0);
        chk("wait_tx_busy", {31'd0, busy}, 32'd1);
        finish_cmd(5);

        // Opcode truncation: 0xE2 -> 0x22 (SUB).
        send_cmd(8'h05, 8'h03, 8'hE2, 8'h02);
        @(negedge clk);
        chk("op_truncated", {26'd0, alu_op}, 32'h22);
        finish_cmd(3);

        // Byte arriving in WAIT_TX is dropped.
        send_cmd(8'h10, 8'h20, 8'h20, 8'h30);
        repeat (4) @(negedge clk);
        send_byte(8'hAA);
        @(negedge clk);
        chk("drop_pulse", {31'd0, rx_drop}, 32'd1);
        chk("drop_still_busy", {31'd0, busy}, 32'd1);
        chk("drop_a_kept", {24'd0, alu_a}, 32'h10);
        @(negedge clk);
        chk("drop_one_cycle", {31'd0, rx_drop}, 32'd0);
        finish_cmd(2);
        send_cmd(8'h33, 8'h11, 8'h22, 8'h22);
        finish_cmd(4);

        // Byte coinciding with i_tx_done is dropped too.
        send_cmd(8'h0F, 8'hF0, 8'h24, 8'h00);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        rx_data = 8'h55;
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        tx_done = 1'b0;
        @(negedge clk);
        chk("coincide_drop", {31'd0, rx_drop}, 32'd1);
        chk("coincide_idle", {31'd0, busy}, 32'd0);
        chk("coincide_a_kept", {24'd0, alu_a}, 32'h0F);

        // Reset in WAIT_TX, then a late i_tx_done.
        send_cmd(8'h44, 8'h11, 8'h20, 8'h55);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_a",  {24'd0, alu_a},   32'd0);
        chk("mid_rst_b",  {24'd0, alu_b},   32'd0);
        chk("mid_rst_op", {26'd0, alu_op},  32'd0);
        chk("mid_rst_tx", {24'd0, tx_data}, 32'd0);
        chk("mid_rst_outputs", {28'd0, tx_start, busy, rx_drop, timeout}, 32'd0);
        pulse_tx_done();
        repeat (3) @(negedge clk);
        chk("late_tx_done_idle", {31'd0, busy}, 32'd0);
        send_byte(8'h11);
        @(negedge clk);
        chk("after_rst_a", {24'd0, alu_a}, 32'h11);
        push_exp(8'h11, 8'h22, 6'h20, 8'h33);
        send_byte(8'h22);
        send_byte(8'h20);
        finish_cmd(4);

        // Inter-byte timeout after a lone first byte.
        send_byte(8'h05);
        tcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (timeout === 1'b1) tcount++;
        end
`ifdef UART_ALU_CTRL_TIMEOUT_EN
        chk("timeout_once", tcount, 32'd1);
        chk("timeout_idle", {31'd0, busy}, 32'd0);
        send_byte(8'h07);
        @(negedge clk);
        chk("timeout_new_a", {24'd0, alu_a}, 32'h07);
        push_exp(8'h07, 8'h01, 6'h20, 8'h08);
        send_byte(8'h01);
        send_byte(8'h20);
`else
        chk("no_timeout", tcount, 32'd0);
        send_byte(8'h07);
        @(negedge clk);
        chk("no_timeout_b", {24'd0, alu_b}, 32'h07);
        chk("no_timeout_a", {24'd0, alu_a}, 32'h05);
        push_exp(8'h05, 8'h07, 6'h20, 8'h0C);
        send_byte(8'h20);
`endif
        finish_cmd(4);

        // Random A/B pairs with ADD.
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            send_cmd(ra, rb, 8'h20, 8'(ra + rb));
            finish_cmd(int'($urandom_range(3, 12)));
        end

        repeat (5) @(negedge clk);
        chk("start_count", starts, pushed);
        chk("queue_empty", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
